apb_reg_slave: RTL
==================

// Module: apb_reg_slave
// PURPOSE
//  APB completer: the responder end of apb_ifc, bound through its slave modport.
//  Holds a bank of NUM_REGS DW_APB-bit registers with byte-strobed writes.
//  Supports a programmable wait-state count, plus per-register read-only and privilege checks.
//  Sits behind the AXI-lite->APB bridge as a register target; also serves as the bridge's bench responder.
// PARAMETERS
//  AW_APB       32  APB address width
//  DW_APB       32  APB data width (multiple of 8)
//  NUM_REGS     16  register count, power of 2, >=2; word-aligned from address 0
//  WAIT_CYCLES  0   pready-low cycles inserted per access phase (0..255)
//  RO_MASK      '0  NUM_REGS bits; bit i=1 -> reg i read-only, returns ro_d slice i
//  PRIV_WR      0   1 -> writes with pprot[0]==0 are refused with pslverr
// PORTS
//  clk       in   1                 clock; all logic on posedge
//  rst       in   1                 synchronous, active-high reset
//  apb       ifc  apb_ifc.slave     paddr/psel/penable/pwrite/pwdata/pstrb/pprot in; pready/prdata/pslverr out
//  ro_d      in   NUM_REGS*DW_APB   read values of read-only regs (slice i = reg i)
//  reg_q     out  NUM_REGS*DW_APB   current contents of writable regs (slice i = reg i)
//  wr_pulse  out  NUM_REGS          1-cycle strobe, bit i, on each committed write to reg i
// BEHAVIOUR
//  Reset: state IDLE, wait counter 0, all regs 0, wr_pulse 0; pready/pslverr/prdata 0 (outputs decoded from IDLE).
//  FSM IDLE -> ACCESS -> IDLE.
//  IDLE:
//   - psel & !penable (setup) -> latch index, pwrite, pwdata, pstrb, error flag; load cnt=WAIT_CYCLES; go ACCESS.
//   - penable without a prior setup is ignored.
//  ACCESS:
//   - pready = (cnt==0); each cycle with psel&penable&cnt!=0 decrements cnt.
//   - psel&penable&pready -> transfer completes; go IDLE.
//   - psel low in ACCESS (protocol abort) -> go IDLE; no commit, no wr_pulse.
//  Inputs changing during ACCESS are ignored; only the values latched at setup are used.
//  Latency:
//   - WAIT_CYCLES=0: pready high in the first access cycle (2-cycle transfer).
//   - In general, transfer length = 2+WAIT_CYCLES cycles.
//  Decode:
//   - idx = paddr[$clog2(NUM_REGS)+1:2].
//   - Error if paddr[1:0]!=0, or paddr >= NUM_REGS*4.
//   - Error if write to a RO_MASK reg.
//   - Error if PRIV_WR & write & !pprot[0].
//  pslverr = pready & err_latched; 0 whenever pready=0.
//  prdata = read & pready & !err ? (RO_MASK[idx] ? ro_d[idx] : reg[idx]) : 0.
//  Write commit:
//   - On the completion edge: for each byte b with pstrb[b]=1, reg[idx][8b+:8] <= pwdata byte b.
//   - wr_pulse[idx]=1 for the following cycle; reg_q updates on that same edge.
//   - An erroring write commits nothing and raises no wr_pulse.
//   - A write with pstrb=0 still completes OKAY and pulses wr_pulse.
//   - pstrb is ignored on reads.
//  Back-to-back: a setup in the cycle right after completion is accepted (no idle cycle needed).
//  Reset asserted mid-transfer -> IDLE next edge, pready 0, no commit, regs cleared.
// STRUCTURE
//  apb_reg_pkg:
//   - typedef enum logic {IDLE, ACCESS} apb_slv_state_t;
//   - localparam RESP_OKAY=1'b0, RESP_SLVERR=1'b1;
//   - function addr_err(paddr, num_regs).
//  Sub-module apb_reg_bank: register array with byte-enable write port, reg_q/wr_pulse outputs, async read mux.
//  Top: FSM, wait counter, decode/latch, response gating.
// TESTING
//  1 WAIT=0: write 0xA5A5_1234 @0x8, pstrb=0xF -> pready in 1st access cycle, pslverr=0; reg2=0xA5A5_1234; wr_pulse[2] 1 cycle.
//  2 WAIT=3: read @0x8 -> pready low 3 access cycles, high in 4th; prdata=0xA5A5_1234 only in that cycle.
//  3 pstrb=0b0010, pwdata=0xFFFF_FFFF @0x8 over 0xA5A5_1234 -> reg2=0xA5A5_FF34.
//  4 Errors:
//    - Read @0x40 (NUM_REGS=16) -> pslverr=1, prdata=0.
//    - Write @0x6 -> pslverr=1, no wr_pulse.
//    - Write to RO reg -> pslverr=1, reg unchanged.
//    - PRIV_WR=1 with pprot=0 -> pslverr=1.
//  5 Back-to-back write@0x0 then read@0x0, no idle cycle -> read returns the new value; both OKAY.
//  6 Abort and reset:
//    - psel dropped mid-wait -> no commit, FSM IDLE.
//    - rst mid-ACCESS -> pready=0 next cycle, all reg_q=0.

Source files
------------

// File: rtl/apb_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_reg_pkg
//  Description : Shared types, response codes and address-decode helper for
//                the APB register completer.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Contents:
//    apb_slv_state_t   completer FSM state (IDLE / ACCESS)
//    RESP_OKAY/SLVERR  pslverr encodings
//    addr_err()        misaligned or out-of-range address check
// ============================================================================
package apb_reg_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_t;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  // Address is zero-extended to 64 bits by the caller so one helper serves
  // every address width.
  function automatic logic addr_err(input logic [63:0] paddr, input int num_regs);
    logic [63:0] limit;
    limit = 64'(num_regs) << 2;
    return (paddr[1:0] != 2'b00) || (paddr >= limit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_ifc.sv
`default_nettype none
// ============================================================================
//  Module      : apb_ifc
//  Description : APB bus bundle with requester (master) and completer (slave)
//                views.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals:
//    paddr/psel/penable/pwrite/pwdata/pstrb/pprot   requester -> completer
//    pready/prdata/pslverr                          completer -> requester
// ============================================================================
interface apb_ifc #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   paddr;
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic [2:0]      pprot;
  logic            pready;
  logic [DW-1:0]   prdata;
  logic            pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    output pready, prdata, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/apb_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : apb_reg_bank
//  Description : Register array with byte-enabled write port, write strobes
//                and an asynchronous read mux that substitutes external
//                values for read-only registers.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports:
//    clk, rst      clock / synchronous active-high reset
//    wr_en_i       commit a write this edge
//    wr_idx_i      register index for the write
//    wr_data_i     write data
//    wr_strb_i     byte enables
//    rd_idx_i      register index for the read mux
//    ro_d_i        read values of read-only registers (slice i = reg i)
//    rd_data_o     read mux output
//    reg_q_o       flattened register contents (slice i = reg i)
//    wr_pulse_o    one-cycle strobe per committed write
// ============================================================================
module apb_reg_bank #(
  parameter int                  NUM_REGS = 16,
  parameter int                  DW       = 32,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en_i,
  input  logic [$clog2(NUM_REGS)-1:0]  wr_idx_i,
  input  logic [DW-1:0]                wr_data_i,
  input  logic [DW/8-1:0]              wr_strb_i,
  input  logic [$clog2(NUM_REGS)-1:0]  rd_idx_i,
  input  logic [NUM_REGS*DW-1:0]       ro_d_i,
  output logic [DW-1:0]                rd_data_o,
  output logic [NUM_REGS*DW-1:0]       reg_q_o,
  output logic [NUM_REGS-1:0]          wr_pulse_o
);
  localparam int SW = DW / 8;

  logic [DW-1:0]       regs_q [NUM_REGS];
  logic [DW-1:0]       w_ro   [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q;
  logic [NUM_REGS-1:0] wr_pulse_d;

  always_comb begin
    wr_pulse_d = '0;
    if (wr_en_i) wr_pulse_d[wr_idx_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= wr_pulse_d;
      if (wr_en_i) begin
        for (int b = 0; b < SW; b++) begin
          if (wr_strb_i[b]) regs_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
    assign reg_q_o[i*DW +: DW] = regs_q[i];
    assign w_ro[i]             = ro_d_i[i*DW +: DW];
  end

  assign rd_data_o  = RO_MASK[rd_idx_i] ? w_ro[rd_idx_i] : regs_q[rd_idx_i];
  assign wr_pulse_o = wr_pulse_q;

endmodule
`default_nettype wire

// File: rtl/apb_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : apb_reg_slave
//  Description : APB completer fronting a bank of byte-strobed registers,
//                with programmable wait states and per-register read-only
//                and privileged-write checks.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports:
//    clk       clock, all logic on posedge
//    rst       synchronous active-high reset
//    apb       APB completer view of apb_ifc
//    ro_d      read values of read-only regs (slice i = reg i)
//    reg_q     current contents of writable regs (slice i = reg i)
//    wr_pulse  one-cycle strobe, bit i, per committed write to reg i
// ============================================================================
module apb_reg_slave
  import apb_reg_pkg::*;
#(
  parameter int                  AW_APB      = 32,
  parameter int                  DW_APB      = 32,
  parameter int                  NUM_REGS    = 16,
  parameter int                  WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  parameter bit                  PRIV_WR     = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  apb_ifc.slave                        apb,
  input  logic [NUM_REGS*DW_APB-1:0]   ro_d,
  output logic [NUM_REGS*DW_APB-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          wr_pulse
);
  localparam int IW = $clog2(NUM_REGS);
  localparam int SW = DW_APB / 8;

  apb_slv_state_t  state_q, state_d;
  logic [7:0]      cnt_q;
  logic [IW-1:0]   idx_q;
  logic            write_q;
  logic            err_q;
  logic [DW_APB-1:0] wdata_q;
  logic [SW-1:0]   strb_q;

  logic            w_setup;
  logic [IW-1:0]   w_idx;
  logic            w_err;
  logic            w_ready;
  logic            w_commit;
  logic [DW_APB-1:0] w_rd_data;

  assign w_setup = apb.psel & ~apb.penable;
  assign w_idx   = apb.paddr[IW+1:2];
  assign w_err   = addr_err(64'(apb.paddr), NUM_REGS)
                 | (apb.pwrite & RO_MASK[w_idx])
                 | (PRIV_WR & apb.pwrite & ~apb.pprot[0]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a dropped psel in ACCESS abandons the transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_setup) state_d = ACCESS;
      ACCESS: begin
        if (!apb.psel)                                state_d = IDLE;
        else if (apb.penable && (cnt_q == 8'd0))      state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: everything is gated by pready so an idle or waiting
  // completer drives zeros.
  always_comb begin
    w_ready     = (state_q == ACCESS) && (cnt_q == 8'd0);
    apb.pready  = w_ready;
    apb.pslverr = w_ready ? err_q : RESP_OKAY;
    apb.prdata  = (w_ready && !write_q && !err_q) ? w_rd_data : '0;
    w_commit    = w_ready && apb.psel && apb.penable && write_q && !err_q;
  end

  // Setup-phase capture and wait counter; bus inputs are only sampled here.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= RESP_OKAY;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (state_q == IDLE && w_setup) begin
      cnt_q   <= 8'(WAIT_CYCLES);
      idx_q   <= w_idx;
      write_q <= apb.pwrite;
      err_q   <= w_err ? RESP_SLVERR : RESP_OKAY;
      wdata_q <= apb.pwdata;
      strb_q  <= apb.pstrb;
    end else if (state_q == ACCESS && apb.psel && apb.penable && cnt_q != 8'd0) begin
      cnt_q   <= cnt_q - 8'd1;
    end
  end

  apb_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .DW       (DW_APB),
    .RO_MASK  (RO_MASK)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (w_commit),
    .wr_idx_i   (idx_q),
    .wr_data_i  (wdata_q),
    .wr_strb_i  (strb_q),
    .rd_idx_i   (idx_q),
    .ro_d_i     (ro_d),
    .rd_data_o  (w_rd_data),
    .reg_q_o    (reg_q),
    .wr_pulse_o (wr_pulse)
  );

endmodule
`default_nettype wire
